// File: rtl/stopwatch_controller.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_controller
// Description : Sequencing controller for a 00-99 stopwatch datapath.
//               Two debounced switches drive an IDLE/RUN/PAUSE/LAP FSM.
//               The FSM issues count-enable ticks, clear strobes and a
//               display-hold flag.
//               The optional macro STOPWATCH_AUTOSTOP_EN enables pausing
//               at MAX_COUNT instead of letting the datapath wrap.
// Revision    : 1.0  initial release
// ============================================================================
module stopwatch_controller #(
  parameter int DEBOUNCE_LIMIT = 250_000,
  parameter int TICK_PERIOD    = 12_500_000,
  parameter int MAX_COUNT      = 99
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic [6:0] i_Count,
  output logic       o_Count_En,
  output logic       o_Count_Clr,
  output logic       o_Hold,
  output logic [1:0] o_State
);

  localparam int DB_W   = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int TICK_W = $clog2(TICK_PERIOD + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [1:0]        raw_sw;
  logic [1:0]        press;
  logic [TICK_W-1:0] tick_cnt;
  logic              running;
  logic              wrap;
  logic              autostop;
  logic              clr_next;
  logic              en_next;
  logic              restart;

  assign raw_sw = {i_Switch_2, i_Switch_1};

  // Per-switch input path: two-flop synchronizer, stability counter, rising-edge pulse
  for (genvar i = 0; i < 2; i++) begin : g_switch
    logic            meta;
    logic            sync;
    logic            level;
    logic            level_d;
    logic            pulse;
    logic [DB_W-1:0] db_cnt;

    // Level flips only after the synced input has disagreed for DEBOUNCE_LIMIT clocks
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        meta    <= 1'b0;
        sync    <= 1'b0;
        level   <= 1'b0;
        level_d <= 1'b0;
        pulse   <= 1'b0;
        db_cnt  <= '0;
      end else begin
        meta    <= raw_sw[i];
        sync    <= meta;
        if (sync == level) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db_cnt <= '0;
          level  <= sync;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
        level_d <= level;
        pulse   <= level & ~level_d;
      end
    end

    assign press[i] = pulse;
  end

  assign running = (state == ST_RUN) || (state == ST_LAP);
  assign wrap    = running && (tick_cnt == TICK_LAST);
  // Entering RUN from a stopped state restarts the tick phase; LAP->RUN keeps it
  assign restart = ((state == ST_IDLE) || (state == ST_PAUSE)) && (state_next == ST_RUN);

`ifdef STOPWATCH_AUTOSTOP_EN
  logic armed;

  assign autostop = wrap && armed && (i_Count == 7'(MAX_COUNT));

  // After an auto-stop, stay disarmed until the count has moved off MAX_COUNT
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      armed <= 1'b1;
    end else if (autostop) begin
      armed <= 1'b0;
    end else if (i_Count != 7'(MAX_COUNT)) begin
      armed <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign autostop   = 1'b0;
  assign unused_cfg = ^{i_Count, 7'(MAX_COUNT)};
`endif

  // Next-state and strobe decode; P1 takes priority over P2, auto-stop over both
  always_comb begin
    state_next = state;
    clr_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press[0]) begin
          state_next = ST_RUN;
        end else if (press[1]) begin
          state_next = ST_IDLE;
          clr_next   = 1'b1;
        end
      end
      ST_RUN: begin
        if (press[0]) begin
          state_next = ST_PAUSE;
        end else if (press[1]) begin
          state_next = ST_LAP;
        end
      end
      ST_PAUSE: begin
        if (press[0]) begin
          state_next = ST_RUN;
        end else if (press[1]) begin
          state_next = ST_IDLE;
          clr_next   = 1'b1;
        end
      end
      ST_LAP: begin
        if (press[0]) begin
          state_next = ST_PAUSE;
        end else if (press[1]) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (autostop) begin
      state_next = ST_PAUSE;
      clr_next   = 1'b0;
    end
    en_next = wrap && ((state_next == ST_RUN) || (state_next == ST_LAP));
  end

  // State and registered output strobes
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= ST_IDLE;
      o_Count_En  <= 1'b0;
      o_Count_Clr <= 1'b0;
      o_Hold      <= 1'b0;
    end else begin
      state       <= state_next;
      o_Count_En  <= en_next;
      o_Count_Clr <= clr_next;
      o_Hold      <= (state_next == ST_LAP);
    end
  end

  // Tick phase counter, advancing only while the stopwatch is counting
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tick_cnt <= '0;
    end else if (restart) begin
      tick_cnt <= '0;
    end else if (running) begin
      tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
    end
  end

  assign o_State = state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_controller
// Description : Directed self-checking bench for stopwatch_controller
//               (DEBOUNCE_LIMIT=4, TICK_PERIOD=10).
// Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw1 = 1'b0;
  logic       sw2 = 1'b0;
  logic [6:0] count = 7'd0;
  logic       en;
  logic       clr;
  logic       hold;
  logic [1:0] st;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int overlap = 0;
  int en_q[$];

  stopwatch_controller #(
    .DEBOUNCE_LIMIT(4),
    .TICK_PERIOD(10),
    .MAX_COUNT(99)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .i_Switch_1(sw1),
    .i_Switch_2(sw2),
    .i_Count(count),
    .o_Count_En(en),
    .o_Count_Clr(clr),
    .o_Hold(hold),
    .o_State(st)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record count-enable pulse times and any enable/clear overlap
  always @(negedge clk) begin
    if (en === 1'b1) en_q.push_back(cyc);
    if (en === 1'b1 && clr === 1'b1) overlap++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold switches for 9 clocks, then release; captures observations around edge 8
  task automatic press(input bit a, input bit b,
                       output logic [1:0] st_before, output logic [1:0] st_after,
                       output logic hold_after, output logic clr_after,
                       output int clr_cnt);
    clr_cnt = 0;
    sw1 = a;
    sw2 = b;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
      if (clr === 1'b1) clr_cnt++;
      if (k == 7) st_before = st;
      if (k == 8) begin
        st_after   = st;
        hold_after = hold;
        clr_after  = clr;
      end
      if (k == 9) begin
        sw1 = 1'b0;
        sw2 = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    checks++;
    if ({st, en, clr, hold} !== 5'd0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected 00000", {st, en, clr, hold});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step(1);
      checks++;
      if ({st, en, clr, hold} !== 5'd0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d: got %b expected 00000", k, {st, en, clr, hold});
      end
    end
  endtask

  task automatic test_start();
    sw1 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (k == 20) sw1 = 1'b0;
      if (k == 7) begin
        checks++;
        if (st !== 2'd0) begin
          errors++;
          $display("FAIL start_early: state %0d expected 0", st);
        end
      end
      if (k == 8) begin
        checks++;
        if (st !== 2'd1) begin
          errors++;
          $display("FAIL start_latency: state %0d expected 1", st);
        end
      end
      checks++;
      if (en !== ((k == 18) || (k == 28) || (k == 38))) begin
        errors++;
        $display("FAIL start_tick k=%0d: count_en %b expected %b", k, en,
                 (k == 18) || (k == 28) || (k == 38));
      end
    end
  endtask

  task automatic test_glitch();
    sw1 = 1'b1;
    step(3);
    sw1 = 1'b0;
    step(20);
    checks++;
    if (st !== 2'd1) begin
      errors++;
      $display("FAIL glitch: state %0d expected 1", st);
    end
  endtask

  task automatic test_lap();
    logic [1:0] b4, af;
    logic       h, c;
    int         n;
    en_q.delete();
    press(1'b0, 1'b1, b4, af, h, c, n);
    checks++;
    if (b4 !== 2'd1 || af !== 2'd3 || h !== 1'b1) begin
      errors++;
      $display("FAIL lap_enter: before %0d after %0d hold %b expected 1 3 1", b4, af, h);
    end
    step(15);
    press(1'b0, 1'b1, b4, af, h, c, n);
    checks++;
    if (b4 !== 2'd3 || af !== 2'd1 || h !== 1'b0) begin
      errors++;
      $display("FAIL lap_exit: before %0d after %0d hold %b expected 3 1 0", b4, af, h);
    end
    step(15);
    checks++;
    if (en_q.size() < 5) begin
      errors++;
      $display("FAIL lap_tick_count: pulses %0d expected at least 5", en_q.size());
    end
    for (int i = 1; i < en_q.size(); i++) begin
      checks++;
      if (en_q[i] - en_q[i-1] != 10) begin
        errors++;
        $display("FAIL lap_tick_spacing %0d: spacing %0d expected 10", i, en_q[i] - en_q[i-1]);
      end
    end
  endtask

  task automatic test_pause_clear();
    logic [1:0] b4, af;
    logic       h, c;
    int         n;
    press(1'b1, 1'b0, b4, af, h, c, n);
    checks++;
    if (b4 !== 2'd1 || af !== 2'd2) begin
      errors++;
      $display("FAIL pause_enter: before %0d after %0d expected 1 2", b4, af);
    end
    en_q.delete();
    step(30);
    checks++;
    if (en_q.size() != 0) begin
      errors++;
      $display("FAIL pause_frozen: pulses %0d expected 0", en_q.size());
    end
    press(1'b0, 1'b1, b4, af, h, c, n);
    checks++;
    if (b4 !== 2'd2 || af !== 2'd0 || c !== 1'b1 || n != 1) begin
      errors++;
      $display("FAIL pause_clear: before %0d after %0d clr %b pulses %0d expected 2 0 1 1",
               b4, af, c, n);
    end
    press(1'b1, 1'b1, b4, af, h, c, n);
    checks++;
    if (b4 !== 2'd0 || af !== 2'd1 || n != 0) begin
      errors++;
      $display("FAIL both_pressed: before %0d after %0d clr pulses %0d expected 0 1 0",
               b4, af, n);
    end
  endtask

  task automatic test_autostop();
    int seen;
    count = 7'd99;
    seen  = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (en === 1'b1) seen++;
    end
`ifdef STOPWATCH_AUTOSTOP_EN
    begin
      logic [1:0] b4, af;
      logic       h, c;
      int         n;
      checks++;
      if (seen != 0 || st !== 2'd2 || hold !== 1'b0) begin
        errors++;
        $display("FAIL autostop: pulses %0d state %0d hold %b expected 0 2 0", seen, st, hold);
      end
      press(1'b1, 1'b0, b4, af, h, c, n);
      checks++;
      if (af !== 2'd1) begin
        errors++;
        $display("FAIL autostop_resume: state %0d expected 1", af);
      end
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        step(1);
        if (en === 1'b1) seen++;
      end
      checks++;
      if (seen != 1 || st !== 2'd1) begin
        errors++;
        $display("FAIL autostop_rearm: pulses %0d state %0d expected 1 1", seen, st);
      end
    end
`else
    checks++;
    if (seen != 1 || st !== 2'd1) begin
      errors++;
      $display("FAIL no_autostop: pulses %0d state %0d expected 1 1", seen, st);
    end
`endif
    count = 7'd0;
  endtask

  task automatic test_reset_mid();
    int k;
    k = 0;
    while (en !== 1'b1 && k < 12) begin
      step(1);
      k++;
    end
    checks++;
    if (en !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_wait: count_en %b expected 1 within 12 clocks", en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({st, en, clr, hold} !== 5'd0) begin
      errors++;
      $display("FAIL reset_async: got %b expected 00000", {st, en, clr, hold});
    end
    step(2);
    rst_n = 1'b1;
    step(5);
    checks++;
    if ({st, en, clr, hold} !== 5'd0) begin
      errors++;
      $display("FAIL reset_after: got %b expected 00000", {st, en, clr, hold});
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_glitch();
    test_lap();
    test_pause_clear();
    test_autostop();
    test_reset_mid();
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL en_clr_overlap: cycles %0d expected 0", overlap);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
